// File: rtl/isr_dispatch.sv
// Queues radicands in a small FIFO and runs them one at a time through an external
// square-root engine, returning each root (or a timeout error) together with its radicand.
module isr_dispatch #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [63:0]              in_value,
   output logic                     in_ready,
   output logic                     isr_start,
   output logic [63:0]              isr_value,
   input  logic                     isr_done,
   input  logic [31:0]              isr_result,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [63:0]              out_value,
   output logic [31:0]              out_root,
   output logic                     out_err,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(DEPTH);
   localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

   state_t          state;
   logic [63:0]     mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   wait_cnt;
   logic            push;
   logic            pop;

   assign in_ready  = (count != FULL_CNT);
   assign push      = in_valid && in_ready;
   assign pop       = (state == IDLE) && (count != '0);
   // The engine is held in reset for as long as we are, and restarted by the START cycle.
   assign isr_start = reset || (state == START);

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= in_value;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         wait_cnt  <= '0;
         isr_value <= '0;
         out_valid <= 1'b0;
         out_err   <= 1'b0;
         out_root  <= '0;
         out_value <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end

         case (state)
            IDLE: begin
               if (pop) begin
                  isr_value <= mem[rd_ptr];
                  state     <= START;
               end
            end
            START: begin
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               // isr_done may still be stale from the previous job in the first WAIT cycle.
               if ((wait_cnt != '0) && isr_done) begin
                  out_root  <= isr_result;
                  out_value <= isr_value;
                  out_err   <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= OUT;
               end else if (wait_cnt == LAST_WAIT) begin
                  out_root  <= '0;
                  out_value <= isr_value;
                  out_err   <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= OUT;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_isr_dispatch.sv
// Directed bench for isr_dispatch with a behavioural square-root engine that answers
// 33 cycles after each start pulse.
module tb_isr_dispatch;

   logic          clock = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [63:0]   in_value;
   logic          in_ready;
   logic          isr_start;
   logic [63:0]   isr_value;
   logic          isr_done;
   logic [31:0]   isr_result;
   logic          out_valid;
   logic          out_ready;
   logic [63:0]   out_value;
   logic [31:0]   out_root;
   logic          out_err;
   logic [2:0]    count;

   int vectors     = 0;
   int miscompares = 0;

   logic [63:0] vals  [6];
   logic [31:0] roots [5];

   logic [5:0] eng_cnt  = '0;
   logic       eng_done = 1'b0;
   logic       tie_done = 1'b0;

   always #5 clock = ~clock;

   isr_dispatch #(.DEPTH(4), .TIMEOUT(64)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_value   (in_value),
      .in_ready   (in_ready),
      .isr_start  (isr_start),
      .isr_value  (isr_value),
      .isr_done   (isr_done),
      .isr_result (isr_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_value  (out_value),
      .out_root   (out_root),
      .out_err    (out_err),
      .count      (count)
   );

   function automatic logic [31:0] isqrt(input logic [63:0] v);
      logic [31:0] r;
      logic [31:0] t;
      logic [63:0] sq;
      r = '0;
      for (int b = 31; b >= 0; b--) begin
         t  = r | (32'd1 << b);
         sq = 64'(t) * 64'(t);
         if (sq <= v) r = t;
      end
      return r;
   endfunction

   // Engine model: restarted by isr_start, done goes high in the 33rd cycle after the start cycle.
   always @(posedge clock) begin
      if (isr_start) begin
         eng_cnt  <= 6'd1;
         eng_done <= 1'b0;
      end else if (!eng_done && eng_cnt != 6'd0) begin
         if (eng_cnt == 6'd32) eng_done <= 1'b1;
         eng_cnt <= eng_cnt + 6'd1;
      end
   end

   assign isr_done   = eng_done && !tie_done;
   assign isr_result = isqrt(isr_value);

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input string tag, input int limit);
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!out_valid && n < limit);
      check({tag, " out_valid"}, 64'(out_valid), 64'd1);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      vals  = '{64'd1, 64'd4, 64'd9, 64'd16, 64'd25, 64'd36};
      roots = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_value  = '0;
      out_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst isr_start", 64'(isr_start), 64'd1);
      check("rst count",     64'(count),     64'd0);
      check("rst out_valid", 64'(out_valid), 64'd0);
      check("rst out_err",   64'(out_err),   64'd0);
      check("rst out_root",  64'(out_root),  64'd0);
      check("rst out_value", out_value,      64'd0);
      check("rst isr_value", isr_value,      64'd0);
      check("rst in_ready",  64'(in_ready),  64'd1);
      step();
      reset = 1'b0;
      @(negedge clock);
      check("idle isr_start", 64'(isr_start), 64'd0);

      // Single job latency: push in cycle T, out_valid first in T+36
      step();
      in_valid = 1'b1;
      in_value = 64'd144;
      step();
      in_valid = 1'b0;
      repeat (34) @(posedge clock);
      @(negedge clock);
      check("lat T+35 out_valid", 64'(out_valid), 64'd0);
      @(negedge clock);
      check("lat T+36 out_valid", 64'(out_valid), 64'd1);
      check("lat out_root",       64'(out_root),  64'd12);
      check("lat out_value",      out_value,      64'd144);
      check("lat out_err",        64'(out_err),   64'd0);
      @(negedge clock);
      check("lat handshake out_valid", 64'(out_valid), 64'd0);

      // Extreme radicands, in order
      repeat (3) @(posedge clock);
      #1;
      in_valid = 1'b1;
      in_value = 64'd0;
      step();
      in_value = 64'hFFFF_FFFF_FFFF_FFFF;
      step();
      in_valid = 1'b0;
      wait_valid("zero", 60);
      check("zero out_root",  64'(out_root), 64'd0);
      check("zero out_value", out_value,     64'd0);
      check("zero out_err",   64'(out_err),  64'd0);
      wait_valid("max", 60);
      check("max out_root",  64'(out_root), 64'h0000_0000_FFFF_FFFF);
      check("max out_value", out_value,     64'hFFFF_FFFF_FFFF_FFFF);
      check("max out_err",   64'(out_err),  64'd0);

      // Back-pressure: 6 offered, 5 accepted, FIFO full
      repeat (3) @(posedge clock);
      #1;
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_value = vals[i];
         @(negedge clock);
         check($sformatf("fill in_ready %0d", i), 64'(in_ready), (i < 5) ? 64'd1 : 64'd0);
         step();
      end
      in_valid = 1'b0;
      @(negedge clock);
      check("full count",    64'(count),    64'd4);
      check("full in_ready", 64'(in_ready), 64'd0);

      // Output held stable while out_ready is low
      wait_valid("hold", 60);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         check($sformatf("hold out_valid %0d", i), 64'(out_valid), 64'd1);
         check($sformatf("hold out_root %0d", i),  64'(out_root),  64'd1);
         check($sformatf("hold out_value %0d", i), out_value,      64'd1);
      end
      out_ready = 1'b1;
      for (int k = 1; k < 5; k++) begin
         wait_valid($sformatf("drain %0d", k), 60);
         check($sformatf("drain out_root %0d", k),  64'(out_root), 64'(roots[k]));
         check($sformatf("drain out_value %0d", k), out_value,     vals[k]);
         check($sformatf("drain out_err %0d", k),   64'(out_err),  64'd0);
      end

      // Timeout with an engine that never finishes
      repeat (3) @(posedge clock);
      #1;
      tie_done = 1'b1;
      in_valid = 1'b1;
      in_value = 64'd25;
      step();
      in_valid = 1'b0;
      repeat (65) @(posedge clock);
      @(negedge clock);
      check("tmo T+66 out_valid", 64'(out_valid), 64'd0);
      @(negedge clock);
      check("tmo out_valid", 64'(out_valid), 64'd1);
      check("tmo out_err",   64'(out_err),   64'd1);
      check("tmo out_root",  64'(out_root),  64'd0);
      check("tmo out_value", out_value,      64'd25);
      step();
      tie_done = 1'b0;

      // Reset in the middle of a job with 3 entries queued
      repeat (2) @(posedge clock);
      #1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_value = 64'(100 + i);
         step();
      end
      in_valid = 1'b0;
      @(negedge clock);
      check("mid count", 64'(count), 64'd3);
      step();
      reset = 1'b1;
      @(negedge clock);
      check("mid rst isr_start", 64'(isr_start), 64'd1);
      step();
      @(negedge clock);
      check("mid rst count",     64'(count),     64'd0);
      check("mid rst out_valid", 64'(out_valid), 64'd0);
      check("mid rst isr_start2", 64'(isr_start), 64'd1);
      step();
      reset = 1'b0;
      @(negedge clock);
      check("post rst out_valid", 64'(out_valid), 64'd0);
      check("post rst count",     64'(count),     64'd0);
      check("post rst isr_start", 64'(isr_start), 64'd0);
      step();
      in_valid = 1'b1;
      in_value = 64'd49;
      step();
      in_valid = 1'b0;
      wait_valid("post rst job", 60);
      check("post rst out_root",  64'(out_root), 64'd7);
      check("post rst out_value", out_value,     64'd49);
      check("post rst out_err",   64'(out_err),  64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/isr_dispatch.md
ISR_DISPATCH -- requirements
Module: isr_dispatch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, input FIFO entries (power of 2, >= 2).
REQ-002 SHALL have parameter TIMEOUT, default 64, max WAIT cycles before abort.
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 in_valid  in  1  upstream value present.
REQ-006 in_value  in  64  radicand.
REQ-007 in_ready  out  1  FIFO can accept; equals !full.
REQ-008 isr_start  out  1  drives square-root engine reset/start.
REQ-009 isr_value  out  64  radicand to engine, held stable for whole job.
REQ-010 isr_done  in  1  engine completion flag (level, sticky until next start).
REQ-011 isr_result  in  32  engine root.
REQ-012 out_valid  out  1  result available.
REQ-013 out_ready  in  1  downstream accepts.
REQ-014 out_value  out  64  radicand belonging to out_root.
REQ-015 out_root  out  32  floor(sqrt(out_value)).
REQ-016 out_err  out  1  job aborted by timeout; out_root = 0.
REQ-017 count  out  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-018 SHALL buffer inputs in a DEPTH-entry circular FIFO; push when in_valid && in_ready; wrap pointers modulo DEPTH.
REQ-019 SHALL leave count unchanged on simultaneous push and pop; no push when full, even if a pop occurs that cycle.
REQ-020 SHALL implement states IDLE, START, WAIT, OUT.
REQ-021 IDLE: if count > 0, pop head into isr_value register -> START; else stay.
REQ-022 START: exactly one cycle; isr_start = 1 -> WAIT; clear WAIT cycle counter.
REQ-023 isr_start SHALL equal reset OR (state == START), combinationally.
REQ-024 WAIT: ignore isr_done in first WAIT cycle; afterwards on isr_done = 1 capture isr_result into out_root, isr_value into out_value, out_err = 0 -> OUT.
REQ-025 WAIT: if counter reaches TIMEOUT without isr_done, out_root = 0, out_value = isr_value, out_err = 1 -> OUT.
REQ-026 OUT: out_valid = 1; out_value/out_root/out_err stable until out_valid && out_ready -> IDLE.
REQ-027 isr_value SHALL not change between pop and return to IDLE.
REQ-028 Results SHALL leave in acceptance order; one job in flight at a time.
REQ-029 Latency: engine raises isr_done 33 cycles after START cycle; input accepted in cycle T with empty FIFO and IDLE -> out_valid in cycle T+36.
REQ-030 FIFO push SHALL continue during START/WAIT/OUT.

Reset
REQ-031 On reset: state IDLE, FIFO pointers and count 0, out_valid 0, out_err 0, out_root 0, out_value 0, isr_value 0, WAIT counter 0.
REQ-032 isr_start SHALL be 1 during every reset cycle, holding the engine reset.
REQ-033 Reset mid-job SHALL discard in-flight job and all FIFO contents; no out_valid in the following cycle.

Verification
REQ-034 Push 144 at cycle T, out_ready = 1 -> out_valid at T+36, out_root = 12, out_value = 144, out_err = 0.
REQ-035 Push 0 then 0xFFFF_FFFF_FFFF_FFFF -> out_root 0 then 0xFFFF_FFFF, in order, no error.
REQ-036 out_ready = 0, DEPTH = 4, push 6 values back-to-back -> 5 accepted, in_ready low from the 6th push, count = 4; release out_ready -> 5 results in order.
REQ-037 Hold out_ready low 10 cycles while out_valid -> out_valid, out_root, out_value unchanged throughout.
REQ-038 isr_done tied 0, push 25 -> after 64 WAIT cycles out_valid = 1, out_err = 1, out_root = 0, out_value = 25.
REQ-039 Assert reset during WAIT with 3 entries queued -> count = 0, out_valid = 0, isr_start = 1 during reset; subsequent push 49 -> out_root = 7.
